mem_access_stage: RTL and testbench

Memory-access stage of the in-order core: consumes the execute stage's `tAluOut` (`memOp` + `regOp`), performs byte/half/word loads and stores against the data-memory port with a request/grant/response handshake, and produces the write-back `tRegOp` for the register file. It back-pressures execute with a ready signal while a memory transaction is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 56 +++++
 rtl/mem_access_stage_lsu_align.sv | 65 ++++++
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 tb/tb_mem_access_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access stage: execute/write-back
// payloads, data-memory request bundle, load/store size codes and FSM states.
package mem_access_stage_pkg;

    localparam int cXLEN     = 32;
    localparam int cRegAddrW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } tMemStateEnum;

    localparam logic [2:0] cLsByte  = 3'b000;
    localparam logic [2:0] cLsHalf  = 3'b001;
    localparam logic [2:0] cLsWord  = 3'b010;
    localparam logic [2:0] cLsByteU = 3'b100;
    localparam logic [2:0] cLsHalfU = 3'b101;

    typedef struct packed {
        logic             read;
        logic             write;
        logic [2:0]       opType;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] wdata;
    } tMemOp;

    typedef struct packed {
        logic                 dv;
        logic [cRegAddrW-1:0] addr;
        logic [cXLEN-1:0]     data;
    } tRegOp;

    typedef struct packed {
        tMemOp memOp;
        tRegOp regOp;
    } tAluOut;

    typedef struct packed {
        logic             req;
        logic             we;
        logic [cXLEN-1:0] addr;
        logic [3:0]       be;
        logic [cXLEN-1:0] wdata;
    } tDmemReq;

    // Access size versus byte offset within the word.
    function automatic logic ls_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            cLsHalf, cLsHalfU: return off[0];
            cLsWord:           return (off != 2'b00);
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_lsu_align.sv
// Combinational lane logic: store byte-enable/data replication, load
// extract plus sign/zero extension, and misaligned/illegal op detection.
module lsu_align
    import mem_access_stage_pkg::*;
(
    input  logic             read,
    input  logic             write,
    input  logic [2:0]       op_type,
    input  logic [1:0]       addr_lo,
    input  logic [cXLEN-1:0] st_data,
    output logic [3:0]       be,
    output logic [cXLEN-1:0] wdata,
    output logic             err,
    input  logic [2:0]       ld_op_type,
    input  logic [1:0]       ld_off,
    input  logic [cXLEN-1:0] rdata,
    output logic [cXLEN-1:0] ld_data
);

    logic [3:0]       st_be_s;
    logic             illegal_s;
    logic [cXLEN-1:0] shifted_s;

    // Store lane formatting; loads always fetch the full word.
    always_comb begin
        st_be_s = 4'b1111;
        wdata   = st_data;
        case (op_type)
            cLsByte: begin
                wdata   = {4{st_data[7:0]}};
                st_be_s = 4'b0001 << addr_lo;
            end
            cLsHalf: begin
                wdata   = {2{st_data[15:0]}};
                st_be_s = 4'b0011 << addr_lo;
            end
            default: begin
                wdata   = st_data;
                st_be_s = 4'b1111;
            end
        endcase
        be = write ? st_be_s : 4'b1111;
    end

    // Unsigned store codes and the reserved funct3 values are rejected.
    always_comb begin
        illegal_s = (read && write) ||
                    (op_type == 3'b011) || (op_type == 3'b110) || (op_type == 3'b111) ||
                    (write && (op_type > cLsWord));
        err       = (read || write) && (illegal_s || ls_misaligned(op_type, addr_lo));
    end

    // Load extraction from the latched offset and size.
    always_comb begin
        shifted_s = rdata >> {ld_off, 3'b000};
        case (ld_op_type)
            cLsByte:  ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            cLsHalf:  ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            cLsByteU: ld_data = {24'h000000, shifted_s[7:0]};
            cLsHalfU: ld_data = {16'h0000, shifted_s[15:0]};
            default:  ld_data = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes non-memory results through in one cycle
// and runs loads/stores over the request/grant/response data-memory port.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int cXLEN = mem_access_stage_pkg::cXLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  tAluOut           iAluOut,
    input  logic             iValid,
    output logic             oReady,
    output logic             oMemReq,
    output logic             oMemWe,
    output logic [cXLEN-1:0] oMemAddr,
    output logic [3:0]       oMemBe,
    output logic [cXLEN-1:0] oMemWdata,
    input  logic             iMemGnt,
    input  logic             iMemRvalid,
    input  logic [cXLEN-1:0] iMemRdata,
    output tRegOp            oRegOp,
    output logic             oMemErr
);

    tMemStateEnum         state_r, state_nxt_s;
    tDmemReq              dmem_r;
    tRegOp                regop_r;
    logic                 err_r;
    logic [2:0]           ld_op_r;
    logic [1:0]           ld_off_r;
    logic [cRegAddrW-1:0] rd_r;

    logic                 xfer_s, accept_s, pass_s, err_s, wb_s;
    logic [3:0]           al_be_s;
    logic [cXLEN-1:0]     al_wdata_s, ld_data_s;
    logic                 al_err_s;

    lsu_align u_align (
        .read       (iAluOut.memOp.read),
        .write      (iAluOut.memOp.write),
        .op_type    (iAluOut.memOp.opType),
        .addr_lo    (iAluOut.memOp.addr[1:0]),
        .st_data    (iAluOut.memOp.wdata),
        .be         (al_be_s),
        .wdata      (al_wdata_s),
        .err        (al_err_s),
        .ld_op_type (ld_op_r),
        .ld_off     (ld_off_r),
        .rdata      (iMemRdata),
        .ld_data    (ld_data_s)
    );

    assign xfer_s = iValid && (state_r == IDLE);

    // Next-state and per-cycle action strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        pass_s      = 1'b0;
        err_s       = 1'b0;
        wb_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!xfer_s) begin
                    state_nxt_s = IDLE;
                end else if (al_err_s) begin
                    err_s = 1'b1;
                end else if (iAluOut.memOp.read || iAluOut.memOp.write) begin
                    accept_s    = 1'b1;
                    state_nxt_s = REQ;
                end else begin
                    pass_s = 1'b1;
                end
            end
            REQ: begin
                if (iMemGnt) begin
                    state_nxt_s = dmem_r.we ? IDLE : RESP;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            RESP: begin
                if (iMemRvalid) begin
                    wb_s        = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Memory request, latched load context, write-back and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_r   <= '0;
            regop_r  <= '0;
            err_r    <= 1'b0;
            ld_op_r  <= 3'b000;
            ld_off_r <= 2'b00;
            rd_r     <= '0;
        end else begin
            err_r <= err_s;
            if (pass_s) begin
                regop_r <= iAluOut.regOp;
            end else if (wb_s) begin
                regop_r.dv   <= (rd_r != '0);
                regop_r.addr <= rd_r;
                regop_r.data <= ld_data_s;
            end else begin
                regop_r <= '0;
            end
            if (accept_s) begin
                dmem_r.req   <= 1'b1;
                dmem_r.we    <= iAluOut.memOp.write;
                dmem_r.addr  <= {iAluOut.memOp.addr[cXLEN-1:2], 2'b00};
                dmem_r.be    <= al_be_s;
                dmem_r.wdata <= al_wdata_s;
                ld_op_r      <= iAluOut.memOp.opType;
                ld_off_r     <= iAluOut.memOp.addr[1:0];
                rd_r         <= iAluOut.regOp.addr;
            end else if ((state_r == REQ) && iMemGnt) begin
                dmem_r.req <= 1'b0;
            end else begin
                dmem_r <= dmem_r;
            end
        end
    end

    assign oReady    = (state_r == IDLE);
    assign oMemReq   = dmem_r.req;
    assign oMemWe    = dmem_r.we;
    assign oMemAddr  = dmem_r.addr;
    assign oMemBe    = dmem_r.be;
    assign oMemWdata = dmem_r.wdata;
    assign oRegOp    = regop_r;
    assign oMemErr   = err_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a write-back scoreboard.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    tAluOut      iAluOut;
    logic        iValid;
    logic        oReady, oMemReq, oMemWe, oMemErr;
    logic [31:0] oMemAddr, oMemWdata, iMemRdata;
    logic [3:0]  oMemBe;
    logic        iMemGnt, iMemRvalid;
    tRegOp       oRegOp;

    int errors = 0;
    int checks = 0;
    tRegOp sb[$];

    mem_access_stage dut (
        .clk        (clk),
        .rst        (rst),
        .iAluOut    (iAluOut),
        .iValid     (iValid),
        .oReady     (oReady),
        .oMemReq    (oMemReq),
        .oMemWe     (oMemWe),
        .oMemAddr   (oMemAddr),
        .oMemBe     (oMemBe),
        .oMemWdata  (oMemWdata),
        .iMemGnt    (iMemGnt),
        .iMemRvalid (iMemRvalid),
        .iMemRdata  (iMemRdata),
        .oRegOp     (oRegOp),
        .oMemErr    (oMemErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic tAluOut mk(input logic rd_en, input logic wr_en, input logic [2:0] op,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [4:0] rd, input logic dv, input logic [31:0] data);
        tAluOut a;
        a = '0;
        a.memOp.read   = rd_en;
        a.memOp.write  = wr_en;
        a.memOp.opType = op;
        a.memOp.addr   = addr;
        a.memOp.wdata  = wd;
        a.regOp.dv     = dv;
        a.regOp.addr   = rd;
        a.regOp.data   = data;
        return a;
    endfunction

    function automatic tRegOp mkreg(input logic [4:0] rd, input logic [31:0] data);
        tRegOp r;
        r.dv   = 1'b1;
        r.addr = rd;
        r.data = data;
        return r;
    endfunction

    // Scoreboard: every write-back strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (oRegOp.dv === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_dv", {26'd0, oRegOp}, 64'd0);
            end else begin
                check("sb_regop", {26'd0, oRegOp}, {26'd0, sb.pop_front()});
            end
        end
    end

    task automatic send(input tAluOut a);
        iAluOut = a;
        iValid  = 1'b1;
        tick();
        iValid  = 1'b0;
        iAluOut = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, oReady, 1'b1);
        check({tag, "_req"}, oMemReq, 1'b0);
        check({tag, "_we"}, oMemWe, 1'b0);
        check({tag, "_addr"}, oMemAddr, 32'd0);
        check({tag, "_be"}, oMemBe, 4'd0);
        check({tag, "_wdata"}, oMemWdata, 32'd0);
        check({tag, "_regop"}, {26'd0, oRegOp}, 64'd0);
        check({tag, "_err"}, oMemErr, 1'b0);
    endtask

    task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
        send(mk(1'b1, 1'b0, op, addr, 32'd0, rd, 1'b0, 32'd0));
        check("ld_req", oMemReq, 1'b1);
        check("ld_addr", oMemAddr, exp_addr);
        check("ld_we", oMemWe, 1'b0);
        check("ld_be", oMemBe, 4'hF);
        check("ld_ready_low", oReady, 1'b0);
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        check("ld_req_drop", oMemReq, 1'b0);
        check("ld_ready_resp", oReady, 1'b0);
        if (rd != 5'd0) sb.push_back(mkreg(rd, exp));
        iMemRvalid = 1'b1;
        iMemRdata  = rdata;
        tick();
        iMemRvalid = 1'b0;
        check("ld_ready_back", oReady, 1'b1);
        check("ld_dv", oRegOp.dv, (rd != 5'd0));
        tick();
        check("ld_sb_drained", sb.size(), 0);
    endtask

    task automatic do_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input int gnt_delay, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        send(mk(1'b0, 1'b1, op, addr, data, 5'd4, 1'b0, 32'd0));
        for (int i = 0; i <= gnt_delay; i++) begin
            check("st_req", oMemReq, 1'b1);
            check("st_we", oMemWe, 1'b1);
            check("st_addr", oMemAddr, exp_addr);
            check("st_be", oMemBe, exp_be);
            check("st_wdata", oMemWdata, exp_wd);
            check("st_ready_low", oReady, 1'b0);
            if (i == gnt_delay) iMemGnt = 1'b1;
            tick();
        end
        iMemGnt = 1'b0;
        check("st_ready_back", oReady, 1'b1);
        check("st_req_drop", oMemReq, 1'b0);
        check("st_no_dv", oRegOp.dv, 1'b0);
    endtask

    task automatic do_bad(input string tag, input tAluOut a);
        send(a);
        check({tag, "_err"}, oMemErr, 1'b1);
        check({tag, "_noreq"}, oMemReq, 1'b0);
        check({tag, "_nodv"}, oRegOp.dv, 1'b0);
        check({tag, "_ready"}, oReady, 1'b1);
        tick();
        check({tag, "_err_pulse"}, oMemErr, 1'b0);
        check({tag, "_noreq2"}, oMemReq, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        iValid     = 1'b0;
        iAluOut    = '0;
        iMemGnt    = 1'b0;
        iMemRvalid = 1'b0;
        iMemRdata  = 32'd0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Pass-through: single then four back-to-back.
        sb.push_back(mkreg(5'd5, 32'hDEADBEEF));
        send(mk(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd5, 1'b1, 32'hDEADBEEF));
        check("pt_dv_t1", oRegOp.dv, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            iAluOut = mk(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'(10 + i), 1'b1, 32'h1000 + 32'(i));
            iValid  = 1'b1;
            sb.push_back(mkreg(5'(10 + i), 32'h1000 + 32'(i)));
            check("pt_ready", oReady, 1'b1);
            tick();
        end
        iValid = 1'b0;
        tick();
        check("pt_sb_drained", sb.size(), 0);

        do_load(cLsByte,  32'h0000_0103, 32'h0000_0100, 5'd7, 32'h8011_2233, 32'hFFFF_FF80);
        do_load(cLsByteU, 32'h0000_0103, 32'h0000_0100, 5'd8, 32'h8011_2233, 32'h0000_0080);
        do_load(cLsHalf,  32'h0000_0022, 32'h0000_0020, 5'd9, 32'h8001_0000, 32'hFFFF_8001);
        do_load(cLsHalfU, 32'h0000_0002, 32'h0000_0000, 5'd1, 32'h8001_0000, 32'h0000_8001);
        do_load(cLsWord,  32'h0000_0044, 32'h0000_0044, 5'd2, 32'hCAFE_F00D, 32'hCAFE_F00D);

        do_store(cLsHalf, 32'h0000_0202, 32'h0000_ABCD, 3, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
        do_store(cLsByte, 32'h0000_0301, 32'h1234_5678, 0, 32'h0000_0300, 4'b0010, 32'h7878_7878);
        do_store(cLsWord, 32'h0000_0400, 32'h1234_5678, 0, 32'h0000_0400, 4'b1111, 32'h1234_5678);

        do_bad("lw_mis", mk(1'b1, 1'b0, cLsWord, 32'h0000_0006, 32'd0, 5'd9, 1'b0, 32'd0));
        do_bad("rw_both", mk(1'b1, 1'b1, cLsWord, 32'h0000_0008, 32'd0, 5'd9, 1'b0, 32'd0));
        do_bad("lh_mis", mk(1'b1, 1'b0, cLsHalfU, 32'h0000_0001, 32'd0, 5'd9, 1'b0, 32'd0));
        do_bad("sbu_ill", mk(1'b0, 1'b1, cLsByteU, 32'h0000_0000, 32'd0, 5'd9, 1'b0, 32'd0));
        do_bad("op111_ill", mk(1'b1, 1'b0, 3'b111, 32'h0000_0000, 32'd0, 5'd9, 1'b0, 32'd0));

        // x0 destination still accesses memory but never writes back.
        do_load(cLsWord, 32'h0000_0010, 32'h0000_0010, 5'd0, 32'h5555_AAAA, 32'h5555_AAAA);

        // Stray handshake inputs while idle.
        iMemRvalid = 1'b1;
        iMemGnt    = 1'b1;
        iMemRdata  = 32'hFFFF_FFFF;
        tick();
        iMemRvalid = 1'b0;
        iMemGnt    = 1'b0;
        check("stray_nodv", oRegOp.dv, 1'b0);
        check("stray_ready", oReady, 1'b1);
        check("stray_noreq", oMemReq, 1'b0);

        // Reset while waiting for load data.
        send(mk(1'b1, 1'b0, cLsWord, 32'h0000_0020, 32'd0, 5'd3, 1'b0, 32'd0));
        iMemGnt = 1'b1;
        tick();
        iMemGnt = 1'b0;
        check("rr_in_resp", oReady, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rr");
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h1111_2222;
        tick();
        iMemRvalid = 1'b0;
        check("rr_stale_nodv", oRegOp.dv, 1'b0);
        check("rr_stale_ready", oReady, 1'b1);
        do_load(cLsWord, 32'h0000_0020, 32'h0000_0020, 5'd3, 32'h3333_4444, 32'h3333_4444);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
